// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// One word per line; loads fill on miss, stores always go to backing memory.
module dcache_ctrl #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SET_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic                     cpu_byte_op,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic                     mem_byte_op,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack
);

    localparam int TagWidth = ADDRESS_WIDTH - SET_WIDTH - 2;
    localparam int Sets     = 1 << SET_WIDTH;

    typedef enum logic [1:0] {StIdle, StRdMiss, StWrThru, StWrDone} state_e;

    state_e state_q, state_d;

    logic [Sets-1:0]       valid_q;
    logic [TagWidth-1:0]   tag_mem  [Sets];
    logic [DATA_WIDTH-1:0] data_mem [Sets];

    logic [ADDRESS_WIDTH-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_WIDTH-1:0]    lat_wdata_q, lat_wdata_d;
    logic                     lat_byte_q, lat_byte_d;

    logic [SET_WIDTH-1:0]  cpu_idx, lat_idx;
    logic [TagWidth-1:0]   cpu_tag, lat_tag;
    logic                  cpu_hit, lat_hit;
    logic [4:0]            rd_sh, wr_sh;
    logic [DATA_WIDTH-1:0] rd_line, rd_byte, lane_mask, merged, upd_data;
    logic                  fill_en, upd_en;

    assign cpu_idx = cpu_addr[SET_WIDTH+1:2];
    assign cpu_tag = cpu_addr[ADDRESS_WIDTH-1:SET_WIDTH+2];
    assign lat_idx = lat_addr_q[SET_WIDTH+1:2];
    assign lat_tag = lat_addr_q[ADDRESS_WIDTH-1:SET_WIDTH+2];

    assign cpu_hit = cpu_req & valid_q[cpu_idx] & (tag_mem[cpu_idx] == cpu_tag);
    assign lat_hit = valid_q[lat_idx] & (tag_mem[lat_idx] == lat_tag);

    // Big-endian lanes: byte offset 0 lives in the most significant byte.
    assign rd_sh     = {~cpu_addr[1:0], 3'b000};
    assign wr_sh     = {~lat_addr_q[1:0], 3'b000};
    assign rd_line   = data_mem[cpu_idx];
    assign rd_byte   = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} & (rd_line >> rd_sh);
    assign lane_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << wr_sh;
    assign merged    = (data_mem[lat_idx] & ~lane_mask)
                     | (({{(DATA_WIDTH-8){1'b0}}, lat_wdata_q[7:0]}) << wr_sh);
    assign upd_data  = lat_byte_q ? merged : lat_wdata_q;

    always_comb begin
        state_d     = state_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_byte_d  = lat_byte_q;
        cpu_rdata   = '0;
        cpu_stall   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_byte_op = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_en     = 1'b0;
        upd_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        cpu_stall   = 1'b1;
                        lat_addr_d  = cpu_addr;
                        lat_wdata_d = cpu_wdata;
                        lat_byte_d  = cpu_byte_op;
                        state_d     = StWrThru;
                    end else if (cpu_hit) begin
                        cpu_rdata = cpu_byte_op ? rd_byte : rd_line;
                    end else begin
                        cpu_stall  = 1'b1;
                        lat_addr_d = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
                        state_d    = StRdMiss;
                    end
                end
            end
            StRdMiss: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = lat_addr_q;
                if (mem_ack) begin
                    fill_en = 1'b1;
                    state_d = StIdle;
                end
            end
            StWrThru: begin
                cpu_stall   = 1'b1;
                mem_req     = 1'b1;
                mem_we      = 1'b1;
                mem_byte_op = lat_byte_q;
                mem_addr    = lat_addr_q;
                mem_wdata   = lat_wdata_q;
                if (mem_ack) begin
                    upd_en  = lat_hit;
                    state_d = StWrDone;
                end
            end
            StWrDone: begin
                state_d = StIdle;
            end
        endcase

        // Reset overrides everything so outputs are quiet even before the edge.
        if (rst) begin
            cpu_rdata   = '0;
            cpu_stall   = 1'b0;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            mem_byte_op = 1'b0;
            mem_addr    = '0;
            mem_wdata   = '0;
            fill_en     = 1'b0;
            upd_en      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_byte_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_byte_q  <= lat_byte_d;
            if (fill_en) valid_q[lat_idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_mem[lat_idx] <= mem_rdata;
            tag_mem[lat_idx]  <= lat_tag;
        end else if (upd_en) begin
            data_mem[lat_idx] <= upd_data;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: miss fill, byte/word hits, write-through
// merge, no-write-allocate and reset abandoning an outstanding fill.
module tb_dcache_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_byte_op;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic        mem_byte_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_checks = 0;
    int n_errors = 0;

    dcache_ctrl #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .SET_WIDTH    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_byte_op(cpu_byte_op),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_byte_op(mem_byte_op),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic cpu_op(input logic we, input logic bop, input logic [31:0] a,
                          input logic [31:0] d);
        cpu_req     = 1'b1;
        cpu_we      = we;
        cpu_byte_op = bop;
        cpu_addr    = a;
        cpu_wdata   = d;
    endtask

    int stalls;

    initial begin
        rst = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        cpu_op(1'b1, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF);
        tick();
        tick();
        settle();
        check_eq("rst_stall", cpu_stall, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_rdata", cpu_rdata, 0);

        rst = 1'b0;
        cpu_req = 1'b0;
        settle();
        check_eq("idle_noreq_stall", cpu_stall, 0);
        tick();

        // Word load miss, ack on the third cycle after the request.
        cpu_op(1'b0, 1'b0, 32'h0001_0000, 32'h0);
        settle();
        stalls = 0;
        if (cpu_stall) stalls++;
        check_eq("miss_no_mem_req_idle", mem_req, 0);
        tick();
        settle();
        check_eq("rdmiss_req", mem_req, 1);
        check_eq("rdmiss_we", mem_we, 0);
        check_eq("rdmiss_addr", mem_addr, 32'h0001_0000);
        if (cpu_stall) stalls++;
        tick();
        settle();
        check_eq("rdmiss_addr_hold", mem_addr, 32'h0001_0000);
        if (cpu_stall) stalls++;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        settle();
        if (cpu_stall) stalls++;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        settle();
        check_eq("miss_stall_cycles", stalls, 4);
        check_eq("fill_hit_stall", cpu_stall, 0);
        check_eq("fill_hit_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check_eq("fill_hit_mem_req", mem_req, 0);
        tick();

        // Byte load hit, lane 2.
        cpu_op(1'b0, 1'b1, 32'h0001_0002, 32'h0);
        settle();
        check_eq("byte_hit_stall", cpu_stall, 0);
        check_eq("byte_hit_rdata", cpu_rdata, 32'h0000_00BE);
        check_eq("byte_hit_mem_req", mem_req, 0);
        tick();

        // Byte store to lane 1: write-through plus merge into the line.
        cpu_op(1'b1, 1'b1, 32'h0001_0001, 32'hAAAA_AA55);
        settle();
        check_eq("bst_stall", cpu_stall, 1);
        check_eq("bst_rdata_zero", cpu_rdata, 0);
        tick();
        settle();
        check_eq("bst_req", mem_req, 1);
        check_eq("bst_we", mem_we, 1);
        check_eq("bst_byte_op", mem_byte_op, 1);
        check_eq("bst_addr", mem_addr, 32'h0001_0001);
        check_eq("bst_wdata_lo", {24'h0, mem_wdata[7:0]}, 32'h55);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        settle();
        check_eq("bst_done_stall", cpu_stall, 0);
        check_eq("bst_done_mem_req", mem_req, 0);
        tick();
        cpu_op(1'b0, 1'b0, 32'h0001_0000, 32'h0);
        settle();
        check_eq("merge_stall", cpu_stall, 0);
        check_eq("merge_rdata", cpu_rdata, 32'hDE55_BEEF);
        check_eq("merge_mem_req", mem_req, 0);
        tick();

        // Word store, same index different tag: no allocate, line untouched.
        cpu_op(1'b1, 1'b0, 32'h0001_0400, 32'h1234_5678);
        settle();
        check_eq("wst_stall", cpu_stall, 1);
        tick();
        settle();
        check_eq("wst_addr", mem_addr, 32'h0001_0400);
        check_eq("wst_wdata", mem_wdata, 32'h1234_5678);
        check_eq("wst_byte_op", mem_byte_op, 0);
        tick();
        settle();
        check_eq("wst_req_hold", mem_req, 1);
        check_eq("wst_wdata_hold", mem_wdata, 32'h1234_5678);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        settle();
        check_eq("wst_done_stall", cpu_stall, 0);
        tick();
        cpu_op(1'b0, 1'b0, 32'h0001_0000, 32'h0);
        settle();
        check_eq("nwa_old_hit_stall", cpu_stall, 0);
        check_eq("nwa_old_hit_rdata", cpu_rdata, 32'hDE55_BEEF);
        cpu_addr = 32'h0001_0400;
        settle();
        check_eq("nwa_new_miss_stall", cpu_stall, 1);
        check_eq("nwa_new_miss_rdata", cpu_rdata, 0);
        tick();
        settle();
        check_eq("nwa_rdmiss_req", mem_req, 1);
        check_eq("nwa_rdmiss_addr", mem_addr, 32'h0001_0400);

        // Reset in RD_MISS before ack; a late ack must not fill.
        rst = 1'b1;
        cpu_req = 1'b0;
        settle();
        check_eq("midrst_stall", cpu_stall, 0);
        check_eq("midrst_mem_req", mem_req, 0);
        tick();
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        settle();
        check_eq("late_ack_mem_req", mem_req, 0);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        settle();
        check_eq("post_rst_idle_req", mem_req, 0);
        cpu_op(1'b0, 1'b0, 32'h0001_0400, 32'h0);
        settle();
        check_eq("post_rst_miss_400", cpu_stall, 1);
        cpu_addr = 32'h0001_0000;
        settle();
        check_eq("post_rst_miss_000", cpu_stall, 1);
        check_eq("post_rst_rdata", cpu_rdata, 0);
        cpu_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
